// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-RAM arbiter: default bus widths and
// the read-return owner tag.
package hack_mem_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

endpackage

// File: rtl/hack_mem_arbiter_if.sv
// Bundle of the CPU port, host port and RAM-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface hack_mem_arbiter_if #(
    parameter int ADDR_W = hack_mem_pkg::ADDR_W,
    parameter int DATA_W = hack_mem_pkg::DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              host_lock;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        output host_gnt, host_rvalid, host_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        input  host_gnt, host_rvalid, host_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/hack_mem_arbiter.sv
// Shares the single-port data RAM between the Hack CPU and a host/loader port:
// CPU fixed priority, bounded host starvation, host lock, 1-cycle read return.
module hack_mem_arbiter #(
    parameter int ADDR_W        = hack_mem_pkg::ADDR_W,
    parameter int DATA_W        = hack_mem_pkg::DATA_W,
    parameter int HOST_MAX_WAIT = 8
) (
    input logic               CLK_100MHz,
    input logic               RST_N,
    hack_mem_arbiter_if.slave bus
);
    import hack_mem_pkg::*;

    localparam int             WCW      = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(HOST_MAX_WAIT);

    logic              cpu_win_s;
    logic              host_win_s;
    logic [WCW-1:0]    wait_cnt_d;
    logic [WCW-1:0]    wait_cnt_q;
    owner_t            rd_owner_d;
    owner_t            rd_owner_q;
    logic [DATA_W-1:0] cpu_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] host_rdata_d;
    logic [DATA_W-1:0] host_rdata_q;

    // Winner selection; grants are suppressed while reset is asserted.
    always_comb begin
        cpu_win_s  = 1'b0;
        host_win_s = 1'b0;
        if (!RST_N) begin
            cpu_win_s  = 1'b0;
            host_win_s = 1'b0;
        end else if (bus.host_lock) begin
            host_win_s = bus.host_req;
        end else if (bus.cpu_req && bus.host_req) begin
            host_win_s = (wait_cnt_q == WAIT_MAX);
            cpu_win_s  = (wait_cnt_q != WAIT_MAX);
        end else begin
            cpu_win_s  = bus.cpu_req;
            host_win_s = bus.host_req;
        end
    end

    // RAM drive muxed from the winner; idle cycles never write.
    always_comb begin
        bus.cpu_gnt   = cpu_win_s;
        bus.host_gnt  = host_win_s;
        bus.cpu_stall = bus.cpu_req & ~cpu_win_s & RST_N;
        bus.ram_en    = cpu_win_s | host_win_s;
        if (host_win_s) begin
            bus.ram_we    = bus.host_we;
            bus.ram_addr  = bus.host_addr;
            bus.ram_wdata = bus.host_wdata;
        end else if (cpu_win_s) begin
            bus.ram_we    = bus.cpu_we;
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_wdata = bus.cpu_wdata;
        end else begin
            bus.ram_we    = 1'b0;
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_wdata = bus.cpu_wdata;
        end
    end

    // Host starvation counter: saturating count of lost cycles while requesting.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (host_win_s) begin
            wait_cnt_d = {WCW{1'b0}};
        end else if (bus.host_req && RST_N && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WCW'(1'b1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Read-owner tag for the access accepted this cycle.
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (cpu_win_s && !bus.cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (host_win_s && !bus.host_we) begin
            rd_owner_d = OWN_HOST;
        end else begin
            rd_owner_d = OWN_NONE;
        end
    end

    // Return path: the owner sees RAM data now and keeps it afterwards.
    always_comb begin
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        case (rd_owner_q)
            OWN_CPU:  cpu_rdata_d  = bus.ram_rdata;
            OWN_HOST: host_rdata_d = bus.ram_rdata;
            default: begin
                cpu_rdata_d  = cpu_rdata_q;
                host_rdata_d = host_rdata_q;
            end
        endcase
        bus.cpu_rvalid  = (rd_owner_q == OWN_CPU);
        bus.host_rvalid = (rd_owner_q == OWN_HOST);
        bus.cpu_rdata   = cpu_rdata_d;
        bus.host_rdata  = host_rdata_d;
    end

    // State registers.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt_q   <= {WCW{1'b0}};
            rd_owner_q   <= OWN_NONE;
            cpu_rdata_q  <= {DATA_W{1'b0}};
            host_rdata_q <= {DATA_W{1'b0}};
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            rd_owner_q   <= rd_owner_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

endmodule

// File: doc/hack_mem_arbiter.md
# hack_mem_arbiter

Two-port arbiter that shares the single-port 2048x16 data RAM between the Hack CPU data port and a host/loader port (UART bootloader, debug monitor). It sits between the requesters and the RAM instance. It issues at most one RAM access per clock and returns read data one cycle later to the port that issued the read. The CPU has fixed priority, with a bounded-starvation override and a host lock mode for program/data loading.

## Interface
- `ADDR_W`, 11: RAM word address width (2048 words).
- `DATA_W`, 16: data width.
- `HOST_MAX_WAIT`, 8: number of consecutive lost contested cycles before the host is forced a grant; must be ≥1.
- `CLK_100MHz` input 1: sole clock; all state updates on rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `cpu_req` input 1: CPU access request, held until granted.
- `cpu_we` input 1: 1 = write, 0 = read.
- `cpu_addr` input ADDR_W: CPU word address.
- `cpu_wdata` input DATA_W: CPU write data.
- `cpu_gnt` output 1: access accepted this cycle (combinational).
- `cpu_rvalid` output 1: `cpu_rdata` valid (registered).
- `cpu_rdata` output DATA_W: read data.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_gnt`, `host_rvalid`, `host_rdata`: same as the CPU port, for the host.
- `host_lock` input 1: 1 = CPU is never granted.
- `cpu_stall` output 1: `cpu_req & ~cpu_gnt`.
- `ram_en` output 1: RAM access strobe.
- `ram_we` output 1: RAM write enable.
- `ram_addr` output ADDR_W: RAM address.
- `ram_wdata` output DATA_W: RAM write data.
- `ram_rdata` input DATA_W: RAM read data, valid one cycle after `ram_en & ~ram_we`.

## Operation
- **Accept rule:** a port's access is accepted in a cycle when its `req` and `gnt` are both 1. At most one `gnt` is high in any cycle.
- **Winner selection**, evaluated in order:
  1. If `host_lock` is 1, the host wins if requesting; the CPU never wins.
  2. If only one port is requesting, that port wins.
  3. If both are requesting, the host wins when `wait_cnt == HOST_MAX_WAIT`; otherwise the CPU wins.
- **RAM drive:**
  - `ram_en = cpu_gnt | host_gnt`.
  - `ram_we`, `ram_addr` and `ram_wdata` are muxed from the winning port.
  - When no port wins, `ram_we` = 0 and the other RAM outputs are don't-care.
- **`wait_cnt`** (width clog2(HOST_MAX_WAIT+1)):
  - Increments, saturating at HOST_MAX_WAIT, on each cycle where `host_req` is 1 and the host does not win.
  - Clears to 0 on any host grant.
  - Holds when `host_req` is 0.
- **Read return:**
  - A registered tag `rd_owner` ∈ {NONE, CPU, HOST} records each accepted read.
  - In the following cycle, the owner's `rvalid` = 1 and its `rdata` = `ram_rdata`. The other port's `rvalid` = 0.
- **Writes** are posted: no response, no `rvalid`.
- **`rdata` hold:** each port's `rdata` is registered and holds its last value when `rvalid` is 0.
- **No forwarding:**
  - A read accepted the cycle after a write to the same address returns the new data, because the write commits at the edge.
  - Same-cycle read/write conflicts cannot occur (single winner).
- **`host_lock` change:** takes effect on the same cycle's arbitration. An in-flight read still returns to its owner.

## Timing
- **Reset** (RST_N low, asynchronous):
  - `rd_owner` = NONE, `wait_cnt` = 0.
  - `cpu_rvalid` and `host_rvalid` = 0; `cpu_rdata` and `host_rdata` = 0.
  - `cpu_gnt` and `host_gnt` are forced to 0, so `ram_en` = 0 and `cpu_stall` = 0.
- **Reset mid-read:** the pending `rvalid` is dropped and is not replayed after reset.
- **Grant latency:** 0 cycles, with the grant in the same cycle as the request when uncontested.
- **Read data latency:** 1 cycle after accept.
- **Throughput:** one access per cycle; back-to-back reads from either port or alternating ports are all supported.
- **Worst-case host wait** under continuous CPU traffic: HOST_MAX_WAIT+1 cycles from first request to grant.
- **Worst-case CPU wait:**
  - Unbounded while `host_lock` is 1.
  - Otherwise 1 cycle per host override.

## Structure
- Shared package `hack_mem_pkg`:
  - `ADDR_W` and `DATA_W` defaults.
  - `owner_t` enum {OWN_NONE, OWN_CPU, OWN_HOST}.
- Single module with no sub-modules. Arbitration is combinational; `rd_owner`, `wait_cnt`, `rvalid`/`rdata` are flops.
- Target size: ~150 lines of RTL.

## Test plan
- **Reset:** hold RST_N low with both `req` = 1 -> both `gnt` 0, `ram_en` 0, `rvalid` 0. Release -> arbitration starts on the next edge.
- **CPU read:** preload addr 5 = 0x1234; CPU read at addr 5 -> `cpu_gnt` the same cycle, `cpu_rvalid` = 1 with `cpu_rdata` = 0x1234 the next cycle, and `host_rvalid` stays 0.
- **Write then read:** host writes 0xBEEF to addr 2047, then reads addr 2047 the next cycle -> `host_rdata` = 0xBEEF.
- **Starvation bound:** HOST_MAX_WAIT = 3, both ports requesting continuously -> CPU granted 3 cycles, host granted on the 4th, then CPU again; `wait_cnt` returns to 0.
- **Host lock:** `host_lock` = 1 with both requesting -> only the host is granted and `cpu_stall` = 1. Deassert the lock -> CPU granted the same cycle.
- **Reset mid-read:** assert RST_N low in the cycle after a CPU read is accepted -> no `cpu_rvalid` during or after reset.
